mips32_prog_loader: RTL and testbench
=====================================

# mips32_prog_loader

Streams a program into the MIPS32 core's instruction memory over a valid/ready word interface, then releases the core by asserting `core_run`. Sits directly upstream of the MIPS32 core. It replaces direct testbench pokes of `I_Mem` with a synthesizable load path, and reports the word count and an additive checksum for host-side verification.

## Interface
- `DEPTH`, 1024: instruction memory depth in 32-bit words; power of two, ≥ 2.
- `ADDR_W`, $clog2(DEPTH): instruction memory address width (derived).
- `clk_1`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a load from IDLE.
- `abort`  in  1  one-cycle pulse; returns to IDLE from any state.
- `in_valid`  in  1  `in_data` / `in_last` are valid.
- `in_data`  in  32  instruction word.
- `in_last`  in  1  marks the final word of the program.
- `in_ready`  out  1  loader accepts a word this cycle.
- `imem_we`  out  1  instruction memory write strobe, registered.
- `imem_addr`  out  ADDR_W  write address, registered.
- `imem_wdata`  out  32  write data, registered.
- `core_run`  out  1  releases the core; level signal.
- `busy`  out  1  state is LOAD or FLUSH.
- `err`  out  1  overflow occurred; sticky until `start`, `abort` or `rst`.
- `word_count`  out  ADDR_W+1  words written in the current or last load.
- `checksum`  out  32  sum of accepted words, mod 2^32.

## Operation
- States:
  - IDLE: `start` → LOAD; `ptr`, `word_count`, `checksum` and `err` cleared.
  - LOAD: on each accepted beat, if `in_last` → FLUSH; else if `ptr == DEPTH-1` → ERR; else stay in LOAD.
  - FLUSH: → RUN unconditionally.
  - RUN and ERR: held until `abort` or `rst`.
- `in_ready` = (state == LOAD), combinational from state only. It does not depend on `in_valid`.
- Beat accepted when `in_valid & in_ready` at a rising edge. On acceptance:
  - `imem_we` ← 1, `imem_addr` ← `ptr`, `imem_wdata` ← `in_data`.
  - `ptr` ← `ptr`+1; `word_count` ← `word_count`+1.
  - `checksum` ← `checksum` + `in_data`, truncated to 32 bits.
- With no acceptance, `imem_we` ← 0. `imem_addr` and `imem_wdata` hold their values.
- Addresses are contiguous from 0 with no gaps, regardless of bubbles on `in_valid`.
- `core_run` ← 1 on the FLUSH→RUN edge and stays 1 in RUN. It is 0 in every other state.
- `err` ← 1 on the LOAD→ERR edge. `core_run` never asserts from ERR.
- A beat with `in_last` at `ptr == DEPTH-1` is a normal finish: no `err`.
- `start` outside IDLE is ignored.
- `abort` in any state:
  - next state IDLE; `core_run` ← 0, `imem_we` ← 0, `err` ← 0.
  - `word_count` and `checksum` hold.
  - If `abort` coincides with an accepted beat, `abort` wins: no write, no counter update.
- `abort` and `start` in the same cycle: `abort` wins and the state stays IDLE.
- `in_data` is not inspected; the loader does not decode opcodes.

## Timing
- Reset values: state IDLE; all outputs 0, including `in_ready`, `core_run`, `err`, `word_count` and `checksum`.
- `rst` asserted mid-load or mid-RUN: `core_run` and `imem_we` drop immediately (asynchronous). No partial write completes after reset.
- `start` sampled at edge E → `in_ready` high from E onward. The first beat can be accepted at edge E+1.
- Beat accepted at edge N → `imem_we` high in cycle N..N+1. The memory captures the write at edge N+1.
- Last beat accepted at edge N: FLUSH during N..N+1, then `core_run` high from edge N+1. The core therefore starts fetching no earlier than the edge after the last write commits.
- Sustained throughput: one word per cycle while `in_valid` stays high.
- `busy` is high from the `start` edge through the FLUSH cycle. It is low in RUN, ERR and IDLE.

## Test plan
- Three-word load: words 0x280A00C8, 0x28020001, 0xFC000000 (last flagged), `in_valid` held high.
  - Required: writes to addresses 0, 1, 2 on three consecutive cycles.
  - Required: `core_run` rises one cycle after the final `imem_we` pulse.
  - Required: `word_count` = 3, `checksum` = 0x4C0C00C9, `err` = 0.
- Bubbles: same three words with `in_valid` low for two cycles between beats.
  - Required: `imem_we` pulses only on accepted beats; addresses remain 0, 1, 2; `checksum` = 0x4C0C00C9.
- Overflow with `DEPTH`=4: five words, none flagged last.
  - Required: four writes to addresses 0..3, then `err` = 1 and `in_ready` = 0.
  - Required: fifth word not accepted; `core_run` stays 0; `word_count` = 4.
- Exact fit with `DEPTH`=4: four words with `in_last` on the fourth.
  - Required: `err` = 0; `core_run` = 1; `word_count` = 4.
- Abort mid-load: `abort` pulsed on the same cycle as the third beat.
  - Required: only two writes occur; state returns to IDLE; `in_ready` = 0; `word_count` = 2.
  - Required: a following `start` clears `word_count` to 0.
- Reset during RUN: after a successful load, assert `rst` between clock edges.
  - Required: `core_run` falls in the same timestep.
  - Required: after release, `start` is needed to load again, and all outputs read 0.

Source files
------------

// File: rtl/mips32_prog_loader.sv
// Program loader for the MIPS32 core: accepts a valid/ready word stream,
// writes it to contiguous instruction memory addresses starting at 0, and
// releases the core once the final word has committed. It also reports the
// number of words written and their additive checksum.
module mips32_prog_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_1,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_run,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       checksum
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     wc_q, wc_d;
  logic [31:0]         cs_q, cs_d;
  logic                err_q, err_d;
  logic                run_q, run_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                accept;

  // A beat is taken whenever the stream is valid while loading.
  assign accept = in_valid && (state_q == S_LOAD);

  // Next-state and datapath updates; abort overrides everything, including
  // a beat arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wc_d    = wc_q;
    cs_d    = cs_q;
    err_d   = err_q;
    run_d   = run_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    if (abort) begin
      state_d = S_IDLE;
      err_d   = 1'b0;
      run_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD;
            ptr_d   = '0;
            wc_d    = '0;
            cs_d    = '0;
            err_d   = 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = in_data;
            ptr_d   = ptr_q + ADDR_W'(1);
            wc_d    = wc_q + (ADDR_W + 1)'(1);
            cs_d    = cs_q + in_data;
            if (in_last) begin
              state_d = S_FLUSH;
            end else if (ptr_q == ADDR_W'(DEPTH - 1)) begin
              // Memory is full and the program has not ended.
              state_d = S_ERR;
              err_d   = 1'b1;
            end
          end
        end
        S_FLUSH: begin
          // One cycle for the last write to commit before the core fetches.
          state_d = S_RUN;
          run_d   = 1'b1;
        end
        S_RUN: begin
          run_d = 1'b1;
        end
        S_ERR: begin
          run_d = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          run_d   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      wc_q    <= '0;
      cs_q    <= '0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wc_q    <= wc_d;
      cs_q    <= cs_d;
      err_q   <= err_d;
      run_q   <= run_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_ready   = (state_q == S_LOAD);
  assign busy       = (state_q == S_LOAD) || (state_q == S_FLUSH);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_run   = run_q;
  assign err        = err_q;
  assign word_count = wc_q;
  assign checksum   = cs_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Bench for mips32_prog_loader: directed test-plan scenarios followed by
// randomized loads, checked against a program-level reference model.
module tb_mips32_prog_loader;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk_1 = 1'b0;
  logic          rst, start, abort, in_valid, in_last;
  logic [31:0]   in_data;
  logic          in_ready, imem_we, core_run, busy, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata, checksum;
  logic [AW:0]   word_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Program to send, writes observed on the memory port, and the totals
  // left behind by the previous load.
  logic [31:0] prog_q[$];
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          last_wc;
  logic [31:0] last_cs;

  mips32_prog_loader #(.DEPTH(DEPTH)) dut (
    .clk_1      (clk_1),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_run   (core_run),
    .busy       (busy),
    .err        (err),
    .word_count (word_count),
    .checksum   (checksum)
  );

  always #5 clk_1 = ~clk_1;

  // Memory-side monitor: a write commits at the edge where imem_we is seen high.
  always @(posedge clk_1) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(int'(imem_addr));
      wr_data_q.push_back(imem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk_1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sends prog_q as one load from IDLE. With has_last the final word carries
  // in_last; without it the stream is DEPTH+1 words and must overflow.
  task automatic run_load(input bit has_last, input int bub_max, input string nm);
    int          len;
    int          acc;
    int          nb;
    logic [31:0] cs;
    len = prog_q.size();
    acc = has_last ? len : DEPTH;
    cs  = 32'd0;
    for (int i = 0; i < acc; i++) cs = cs + prog_q[i];
    wr_addr_q.delete();
    wr_data_q.delete();

    start = 1'b1;
    tick();
    start = 1'b0;
    chk({nm, ":ready_after_start"}, in_ready, 1);
    chk({nm, ":busy_after_start"}, busy, 1);
    chk({nm, ":wc_cleared"}, word_count, 0);
    chk({nm, ":cs_cleared"}, checksum, 0);
    chk({nm, ":err_cleared"}, err, 0);

    for (int i = 0; i < len; i++) begin
      nb = (bub_max > 0) ? int'($urandom_range(bub_max, 0)) : 0;
      in_valid = 1'b0;
      for (int b = 0; b < nb; b++) begin
        tick();
        chk({nm, ":we_low_in_bubble"}, imem_we, 0);
      end
      in_valid = 1'b1;
      in_data  = prog_q[i];
      in_last  = has_last && (i == len - 1);
      chk({nm, ":ready_before_beat"}, in_ready, (i < DEPTH) ? 1 : 0);
      tick();
      chk({nm, ":we_after_beat"}, imem_we, (i < DEPTH) ? 1 : 0);
      if (i < DEPTH) begin
        chk({nm, ":addr"}, imem_addr, i);
        chk({nm, ":wdata"}, imem_wdata, prog_q[i]);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    if (has_last) begin
      chk({nm, ":flush_busy"}, busy, 1);
      chk({nm, ":flush_no_run"}, core_run, 0);
      tick();
      chk({nm, ":run_high"}, core_run, 1);
      chk({nm, ":run_not_busy"}, busy, 0);
      chk({nm, ":run_we_low"}, imem_we, 0);
      chk({nm, ":run_ready_low"}, in_ready, 0);
      chk({nm, ":run_err"}, err, 0);
    end else begin
      tick();
      chk({nm, ":ovf_err"}, err, 1);
      chk({nm, ":ovf_no_run"}, core_run, 0);
      chk({nm, ":ovf_ready_low"}, in_ready, 0);
      chk({nm, ":ovf_not_busy"}, busy, 0);
    end
    chk({nm, ":word_count"}, word_count, acc);
    chk({nm, ":checksum"}, checksum, cs);
    chk({nm, ":write_count"}, wr_addr_q.size(), acc);
    for (int j = 0; j < wr_addr_q.size() && j < acc; j++) begin
      chk({nm, ":wr_addr"}, wr_addr_q[j], j);
      chk({nm, ":wr_data"}, wr_data_q[j], prog_q[j]);
    end
    last_wc = acc;
    last_cs = cs;
  endtask

  // Return to IDLE from RUN/ERR; totals must survive the abort.
  task automatic do_abort(input string nm);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk({nm, ":abort_run"}, core_run, 0);
    chk({nm, ":abort_err"}, err, 0);
    chk({nm, ":abort_ready"}, in_ready, 0);
    chk({nm, ":abort_wc_hold"}, word_count, last_wc);
    chk({nm, ":abort_cs_hold"}, checksum, last_cs);
  endtask

  initial begin
    bit has_last;
    int len;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = 32'd0;
    last_wc = 0; last_cs = 32'd0;

    // Reset state.
    #2 rst = 1'b1;
    #2;
    chk("rst:ready", in_ready, 0);
    chk("rst:run", core_run, 0);
    chk("rst:err", err, 0);
    chk("rst:wc", word_count, 0);
    chk("rst:cs", checksum, 0);
    chk("rst:we", imem_we, 0);
    chk("rst:busy", busy, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle:ready", in_ready, 0);

    // abort and start together: abort wins, stays IDLE.
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_start:ready", in_ready, 0);
    chk("abort_start:busy", busy, 0);

    // Three-word load, valid held high.
    prog_q = '{32'h280A00C8, 32'h28020001, 32'hFC000000};
    run_load(1'b1, 0, "three");
    chk("three:cs_const", checksum, 32'h4C0C00C9);

    // start while in RUN is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_start:run", core_run, 1);
    chk("run_start:ready", in_ready, 0);
    chk("run_start:wc", word_count, 3);

    // Same words with two-cycle bubbles.
    do_abort("bub");
    run_load(1'b1, 0, "bub_pre");
    do_abort("bub2");
    wr_addr_q.delete(); wr_data_q.delete();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b0;
      if (i > 0) begin
        tick(); chk("bub:we_gap1", imem_we, 0);
        tick(); chk("bub:we_gap2", imem_we, 0);
      end
      in_valid = 1'b1; in_data = prog_q[i]; in_last = (i == 2);
      tick();
      chk("bub:we", imem_we, 1);
      chk("bub:addr", imem_addr, i);
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    chk("bub:run", core_run, 1);
    chk("bub:cs", checksum, 32'h4C0C00C9);
    chk("bub:writes", wr_addr_q.size(), 3);
    last_wc = 3; last_cs = 32'h4C0C00C9;

    // Overflow: DEPTH+1 words, none flagged last.
    do_abort("ovf");
    prog_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
    run_load(1'b0, 0, "ovf");

    // Exact fit: DEPTH words, last on the final one.
    do_abort("fit");
    prog_q = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004};
    run_load(1'b1, 0, "fit");

    // Abort coinciding with the third beat.
    do_abort("mid");
    wr_addr_q.delete(); wr_data_q.delete();
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 32'h00000010; tick();
    in_data = 32'h00000020; tick();
    in_data = 32'h00000030; abort = 1'b1; tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("mid:we", imem_we, 0);
    chk("mid:ready", in_ready, 0);
    chk("mid:busy", busy, 0);
    chk("mid:wc", word_count, 2);
    chk("mid:cs", checksum, 32'h00000030);
    tick();
    chk("mid:writes", wr_addr_q.size(), 2);
    start = 1'b1; tick(); start = 1'b0;
    chk("mid:restart_wc", word_count, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    last_wc = 0; last_cs = 32'd0;

    // Reset during RUN, asserted between edges.
    prog_q = '{32'h00000001, 32'h00000002};
    run_load(1'b1, 0, "prerst");
    #3 rst = 1'b1;
    #1;
    chk("rstrun:run_drop", core_run, 0);
    chk("rstrun:we", imem_we, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rstrun:ready", in_ready, 0);
    chk("rstrun:run", core_run, 0);
    chk("rstrun:err", err, 0);
    chk("rstrun:wc", word_count, 0);
    chk("rstrun:cs", checksum, 0);
    chk("rstrun:addr", imem_addr, 0);
    chk("rstrun:wdata", imem_wdata, 0);
    chk("rstrun:busy", busy, 0);
    tick();
    chk("rstrun:still_idle", in_ready, 0);
    last_wc = 0; last_cs = 32'd0;

    // Randomized loads with random bubbles, lengths and overflows.
    for (int t = 0; t < 16; t++) begin
      has_last = ($urandom_range(3, 0) != 0);
      len = has_last ? int'($urandom_range(DEPTH, 1)) : DEPTH + 1;
      prog_q.delete();
      for (int k = 0; k < len; k++) prog_q.push_back($urandom);
      if (t > 0) do_abort("rnd");
      run_load(has_last, int'($urandom_range(2, 0)), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
